uart_tx_arb: RTL and testbench

Round-robin arbiter that shares the single UART transmitter between `N_REQ` byte-stream requesters, such as a command responder, a status reporter and a debug tap. It sits between the requesters and the `uart_tx` instance. It owns the transmitter's `i_tx_byte_rdy`/`i_tx_byte` inputs and sequences one byte at a time using the transmitter's `o_tx_busy`/`o_tx_done` outputs. An optional burst lock keeps multi-byte messages contiguous without letting any requester starve the others.

---
 rtl/uart_pkg.sv | 10 +
 rtl/rr_pick.sv | 22 ++
 rtl/uart_tx_arb.sv | 85 ++++++++
 tb/tb_uart_tx_arb.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared timing constants, arbiter state encoding and parameter bounds for the uart blocks.
package uart_pkg;
  localparam int CLKS_PER_BIT = 434;
  localparam int CLOCK_PERIOD_NS = 20;
  localparam int N_REQ_MIN = 2;
  localparam int N_REQ_MAX = 8;
  localparam int MAX_BURST_MIN = 1;
  localparam int MAX_BURST_MAX = 255;
  typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT_DONE, ARB_GAP} tx_arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-priority encoder, first set request at or above start_i with wrap-around.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] start_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 found_o
);
  localparam int W = $clog2(N);
  logic [W-1:0] k;
  // scan farthest offset first so the nearest request overwrites it
  always_comb begin
    idx_o = '0;
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = W'((int'(start_i) + i) % N);
      if (req_i[k]) idx_o = k;
    end
  end
  assign found_o = |req_i;
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: shares one uart_tx between N_REQ byte streams with round-robin
// arbitration and a capped burst lock that keeps messages contiguous.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [8*N_REQ-1:0]       i_req_byte,
  input  logic [N_REQ-1:0]         i_req_last,
  output logic [N_REQ-1:0]         o_req_ack,
  output logic                     o_tx_byte_rdy,
  output logic [7:0]               o_tx_byte,
  input  logic                     i_tx_busy,
  input  logic                     i_tx_done,
  output logic [$clog2(N_REQ)-1:0] o_grant_id,
  output logic                     o_busy
);
  localparam int GW = $clog2(N_REQ);
  tx_arb_state_t state_q, state_d;
  logic [GW-1:0] ptr_q, ptr_d, lock_id_q, lock_id_d, gid_q, gid_d, pick, g;
  logic lock_v_q, lock_v_d, rdy_q, rdy_d, found, lock_hit, issue, keep;
  logic [7:0] burst_q, burst_d, cnt, byte_q, byte_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [7:0] req_bytes [N_REQ];
  for (genvar k = 0; k < N_REQ; k++) begin : g_bytes
    assign req_bytes[k] = i_req_byte[8*k +: 8];
  end
  rr_pick #(.N(N_REQ)) u_pick (
    .req_i  (i_req_valid),
    .start_i(ptr_q),
    .idx_o  (pick),
    .found_o(found)
  );
  // an absent lock owner falls back to round-robin in the same cycle
  assign lock_hit = lock_v_q && i_req_valid[lock_id_q];
  assign g = lock_hit ? lock_id_q : pick;
  assign cnt = lock_hit ? burst_q : '0;
  assign keep = !i_req_last[g] && ({1'b0, cnt} + 9'd1 < 9'(MAX_BURST));
  assign issue = (state_q == ARB_IDLE) && !i_tx_busy && found;
  always_comb begin
    state_d = issue ? ARB_WAIT_DONE :
              (state_q == ARB_WAIT_DONE && i_tx_done) ? ARB_GAP :
              (state_q == ARB_GAP) ? ARB_IDLE : state_q;
    rdy_d = issue;
    ack_d = issue ? N_REQ'(1) << g : '0;
    byte_d = issue ? req_bytes[g] : byte_q;
    gid_d = issue ? g : gid_q;
    ptr_d = !issue ? ptr_q : (g == GW'(N_REQ - 1)) ? '0 : g + 1'b1;
    lock_v_d = issue ? keep : lock_v_q;
    lock_id_d = issue ? g : lock_id_q;
    burst_d = !issue ? burst_q : keep ? cnt + 8'd1 : '0;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ARB_IDLE;
      ptr_q <= '0;
      lock_v_q <= 1'b0;
      lock_id_q <= '0;
      burst_q <= '0;
      byte_q <= '0;
      gid_q <= '0;
      rdy_q <= 1'b0;
      ack_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      lock_v_q <= lock_v_d;
      lock_id_q <= lock_id_d;
      burst_q <= burst_d;
      byte_q <= byte_d;
      gid_q <= gid_d;
      rdy_q <= rdy_d;
      ack_q <= ack_d;
    end
  end
  assign o_req_ack = ack_q;
  assign o_tx_byte_rdy = rdy_q;
  assign o_tx_byte = byte_q;
  assign o_grant_id = gid_q;
  assign o_busy = state_q != ARB_IDLE;
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed vectors and corner sequences for uart_tx_arb against a short-frame transmitter model.
module tb_uart_tx_arb;
  localparam int N = 4;
  localparam int MB = 4;
  localparam int FRAME = 12;
  typedef struct {
    logic [3:0]  v;
    logic [31:0] b;
    int          g;
    logic [7:0]  eb;
  } vec_t;
  logic clk = 0, rst = 1;
  logic [N-1:0] valid = '0, last = '0, ack;
  logic [8*N-1:0] bytes = '0;
  logic rdy, busy, tx_busy = 0, tx_done = 0, prev_rdy = 0;
  logic [7:0] txb, cur = '0;
  logic [1:0] gid;
  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  int checks = 0, failures = 0, cnt = 0;
  int g, n3, k, mism, idx;
  bit ok, sd;
  vec_t tv[7];
  int exp_cap[12] = '{3, 3, 3, 3, 0, 3, 3, 3, 3, 0, 3, 3};

  always #10 clk = ~clk;

  uart_tx_arb #(.N_REQ(N), .MAX_BURST(MB)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .i_req_byte(bytes), .i_req_last(last),
    .o_req_ack(ack), .o_tx_byte_rdy(rdy), .o_tx_byte(txb), .i_tx_busy(tx_busy),
    .i_tx_done(tx_done), .o_grant_id(gid), .o_busy(busy)
  );

  // transmitter model: latches byte on start, busy for FRAME cycles, done pulse at end
  always @(posedge clk) begin
    tx_done <= 1'b0;
    if (tx_busy) begin
      if (cnt == 1) begin
        tx_busy <= 1'b0;
        tx_done <= 1'b1;
        rxq.push_back(cur);
      end
      cnt <= cnt - 1;
    end else if (rdy) begin
      tx_busy <= 1'b1;
      cnt <= FRAME;
      cur <= txb;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rdy || ack != '0) begin
      chk("rdy_width", int'(rdy && prev_rdy), 0);
      chk("ack_onehot", $countones(ack), 1);
      chk("rdy_with_ack", int'(rdy), 1);
      chk("no_issue_while_busy", int'(tx_busy), 0);
    end
    prev_rdy = rdy;
  end

  task automatic wait_grant(output int gg, output bit okk);
    okk = 0;
    gg = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rdy) begin
        okk = 1;
        gg = int'(gid);
        break;
      end
    end
    if (!okk) begin
      checks++;
      failures++;
      $display("FAIL grant_timeout: no o_tx_byte_rdy within 100 cycles");
    end
  endtask

  task automatic wait_idle();
    bit okk = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy && !tx_busy) begin
        okk = 1;
        break;
      end
    end
    if (!okk) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: arbiter or transmitter still busy");
    end
  endtask

  task automatic do_reset();
    valid = '0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    rxq.delete();
  endtask

  task automatic rx_compare(input string name);
    int m = 0;
    chk({name, "_rx_count"}, rxq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < rxq.size(); i++) if (rxq[i] != expq[i]) m++;
    chk({name, "_rx_bytes"}, m, 0);
    rxq.delete();
    expq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{4'b0100, 32'h005A0000, 2, 8'h5A};
    tv[1] = '{4'b1111, 32'h13121110, 3, 8'h13};
    tv[2] = '{4'b0011, 32'h0000C1C0, 0, 8'hC0};
    tv[3] = '{4'b0001, 32'h000000D0, 0, 8'hD0};
    tv[4] = '{4'b1001, 32'hE30000E0, 3, 8'hE3};
    tv[5] = '{4'b0110, 32'h00F2F100, 1, 8'hF1};
    tv[6] = '{4'b0011, 32'h0000A1A0, 0, 8'hA0};
    @(negedge clk);
    chk("rst_rdy", int'(rdy), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_byte", int'(txb), 0);
    chk("rst_gid", int'(gid), 0);
    chk("rst_busy", int'(busy), 0);
    do_reset();
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_rdy", int'(rdy), 0);

    last = '1;
    for (int i = 0; i < 7; i++) begin
      valid = tv[i].v;
      bytes = tv[i].b;
      wait_grant(g, ok);
      if (ok) begin
        chk($sformatf("tv%0d_gid", i), g, tv[i].g);
        chk($sformatf("tv%0d_byte", i), int'(txb), int'(tv[i].eb));
        chk($sformatf("tv%0d_ack", i), int'(ack), 1 << tv[i].g);
        chk($sformatf("tv%0d_busy", i), int'(busy), 1);
      end
      valid = '0;
      expq.push_back(tv[i].eb);
      wait_idle();
      chk($sformatf("tv%0d_hold", i), int'(txb), int'(tv[i].eb));
      rx_compare($sformatf("tv%0d", i));
    end

    do_reset();
    valid = 4'hF;
    last = 4'hF;
    bytes = 32'h13121110;
    for (int i = 0; i < 8; i++) begin
      wait_grant(g, ok);
      chk($sformatf("fair%0d_gid", i), g, i % 4);
      chk($sformatf("fair%0d_byte", i), int'(txb), 8'h10 + i % 4);
      expq.push_back(8'(8'h10 + i % 4));
      if (i == 7) valid = '0;
    end
    wait_idle();
    rx_compare("fair");

    do_reset();
    valid = 4'b0010;
    last = 4'b0000;
    bytes = {8'h00, 8'h00, 8'h41, 8'h30};
    wait_grant(g, ok);
    chk("lock_a_gid", g, 1);
    chk("lock_a_byte", int'(txb), 8'h41);
    bytes[15:8] = 8'h42;
    valid = 4'b0011;
    last = 4'b0001;
    wait_grant(g, ok);
    chk("lock_b_gid", g, 1);
    chk("lock_b_byte", int'(txb), 8'h42);
    bytes[15:8] = 8'h43;
    last = 4'b0011;
    wait_grant(g, ok);
    chk("lock_c_gid", g, 1);
    chk("lock_c_byte", int'(txb), 8'h43);
    valid = 4'b0001;
    wait_grant(g, ok);
    chk("lock_r0_gid", g, 0);
    chk("lock_r0_byte", int'(txb), 8'h30);
    valid = '0;
    wait_idle();
    expq = '{8'h41, 8'h42, 8'h43, 8'h30};
    rx_compare("lock");

    do_reset();
    valid = 4'b1000;
    last = 4'b0001;
    bytes = 32'h80000055;
    n3 = 0;
    for (int i = 0; i < 12; i++) begin
      wait_grant(g, ok);
      chk($sformatf("cap%0d_gid", i), g, exp_cap[i]);
      chk($sformatf("cap%0d_byte", i), int'(txb), exp_cap[i] == 3 ? 8'h80 + n3 : 8'h55);
      if (g == 3) begin
        n3++;
        if (n3 == 10) valid[3] = 1'b0;
        else bytes[31:24] = 8'(8'h80 + n3);
      end
      if (i == 0) valid[0] = 1'b1;
    end
    valid = '0;
    wait_idle();
    rxq.delete();

    do_reset();
    valid = 4'b0100;
    last = 4'hF;
    bytes = 32'h00770000;
    wait_grant(g, ok);
    chk("guard_first_gid", g, 2);
    valid = 4'b0010;
    bytes = 32'h00006600;
    repeat (2) @(negedge clk);
    chk("guard_midframe", int'(tx_busy), 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    sd = 0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_done) sd = 1;
      if (rdy) begin
        ok = 1;
        break;
      end
    end
    chk("guard_issued", int'(ok), 1);
    chk("guard_after_done", int'(sd), 1);
    chk("guard_gid", int'(gid), 1);
    chk("guard_byte", int'(txb), 8'h66);
    valid = '0;
    wait_idle();
    expq = '{8'h77, 8'h66};
    rx_compare("guard");

    do_reset();
    valid = 4'(($urandom % 15) + 1);
    last = 4'($urandom);
    bytes = $urandom;
    mism = 0;
    wait_grant(g, ok);
    for (int i = 0; i <= 100; i++) begin
      idx = -1;
      for (int j = 0; j < N; j++) if (ack[j]) idx = j;
      if (idx >= 0) begin
        if (txb != bytes[8*idx +: 8]) mism++;
        expq.push_back(txb);
        bytes[8*idx +: 8] = 8'($urandom);
        last[idx] = 1'($urandom);
        valid[idx] = 1'($urandom);
        valid = valid | 4'($urandom);
        if (valid == '0) valid[idx] = 1'b1;
      end
      if (i == 100) break;
      ok = 0;
      for (int j = 0; j < 100; j++) begin
        @(negedge clk);
        if (tx_done) begin
          ok = 1;
          break;
        end
      end
      k = 0;
      while (ok && k < 20) begin
        @(negedge clk);
        k++;
        if (rdy) break;
      end
      if (i % 20 == 0 || k != 3) chk($sformatf("cadence%0d", i), k, 3);
    end
    chk("cadence_byte_mism", mism, 0);
    valid = '0;
    wait_idle();
    rx_compare("cadence");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
